fizzbuzz_printer: RTL
=====================

Name: fizzbuzz_printer

Overview:
- Sequential FizzBuzz producer: internally counts N = 1..LIMIT and transmits each line as an ASCII byte stream over a valid/ready handshake.
- Each line is "Fizz", "Buzz", "FizzBuzz" or the decimal digits of N, followed by 0x0A.
- Sits at the output end of the FizzBuzz datapath and feeds a UART/console sink or a testbench byte monitor.
- Uses no dividers: mod-3/mod-5 phase counters plus a BCD counter.

Parameters:
- LIMIT, 100, last N emitted; legal range 1..(10^DIGITS - 1).
- DIGITS, 3, number of BCD digits held; must cover LIMIT.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- out_data  output  8  ASCII byte
- out_valid  output  1  out_data holds a valid byte
- out_ready  input  1  sink accepts byte; transfer = out_valid & out_ready at a rising edge
- busy  output  1  high from start acceptance until the final newline transfers
- done  output  1  one-cycle pulse, cycle after the final newline transfers
- number  output  32  current N being emitted, zero-extended; 0 in IDLE

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0x00, busy=0, done=0, number=0, state=IDLE. Counters clear. Takes priority over every other event.
- Reset mid-run: abort at the next edge. The pending byte is dropped and not completed; out_valid=0 from the following cycle.
- States: IDLE, WORD, DIGIT, EOL.
- IDLE: start=1 loads N=1, mod3=1, mod5=1, BCD=...001. Sets busy=1 and enters WORD or DIGIT by classifying N. The first byte is valid on the cycle after start is sampled.
- Classification:
  - mod3==0 and mod5==0: WORD with "FizzBuzz" (8 bytes).
  - mod3==0 only: "Fizz".
  - mod5==0 only: "Buzz".
  - Otherwise DIGIT.
- WORD: emits bytes in order, e.g. F=0x46 i=0x69 z=0x7A z B=0x42 u=0x75 z z. Goes to EOL after the last byte transfers.
- DIGIT: emits BCD digits as 0x30+d, most significant first. Leading zeros are suppressed and at least one digit is emitted. Goes to EOL after the least significant digit transfers.
- EOL: emits 0x0A. On transfer:
  - If N==LIMIT: go to IDLE, busy=0, done=1 for exactly one cycle, number=0.
  - Otherwise: N+1; mod3 and mod5 wrap 2→0 and 4→0; BCD increments with carry 9→0. Classify the new N and enter WORD or DIGIT on the next cycle.
- Handshake:
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on reset.
  - With out_ready held high, one byte transfers per cycle with no bubbles, including across line boundaries.
  - out_valid does not depend combinationally on out_ready.
- start while busy=1 is ignored. start held high in IDLE during the done cycle does not restart until the cycle after done (IDLE sampling).
- number updates in the same cycle the first byte of a new line becomes valid.
- Width rules: N is a 32-bit binary counter. BCD carry-out beyond DIGITS cannot occur for legal LIMIT.

Test Plan:
- LIMIT=15, out_ready=1, pulse start → exactly 58 bytes: "1\n2\nFizz\n4\nBuzz\nFizz\n7\n8\nFizz\nBuzz\n11\nFizz\n13\n14\nFizzBuzz\n". First byte valid one cycle after start. No gaps. done pulses once, the cycle after the final 0x0A. busy=0 afterwards.
- LIMIT=100, out_ready=1 → 413 bytes total: 100 newlines, 6 FizzBuzz, 27 Fizz, 14 Buzz, 101 digit bytes. Line 100 is "Buzz", line 97 is "97". No leading zeros on any line.
- LIMIT=15, out_ready driven by pseudo-random pattern (~50% duty) → same 58-byte sequence. out_data and out_valid stable on every stalled cycle. done asserts once.
- Pulse start again at N=7 mid-run → ignored. Sequence unchanged, single done.
- Assert rst for 1 cycle while "FizzBuzz" is half sent (LIMIT=15) → out_valid=0, busy=0, number=0 next cycle, no done. A new start then produces the full 58-byte sequence from "1\n".
- LIMIT=1 → bytes "1", 0x0A, then done. A back-to-back start the cycle after done repeats the run.

Source files
------------

// File: rtl/fizzbuzz_printer.sv
`default_nettype none
// ============================================================================
// Module   : fizzbuzz_printer
// Purpose  : Counts N = 1..LIMIT and streams each FizzBuzz line as ASCII
//            bytes over a valid/ready handshake. Each line is "Fizz", "Buzz",
//            "FizzBuzz" or the decimal digits of N, terminated by 0x0A.
//            Divisibility comes from mod-3/mod-5 phase counters and the
//            decimal text from a BCD counter, so no dividers are needed.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            start     - begin a run (sampled only when idle)
//            out_data  - ASCII byte
//            out_valid - out_data holds a valid byte
//            out_ready - sink accepts byte (transfer = out_valid & out_ready)
//            busy      - run in progress
//            done      - one-cycle pulse after the final newline transfers
//            number    - current N (0 when idle)
// Revision : 1.0 - initial release
// ============================================================================
module fizzbuzz_printer #(
    parameter int unsigned LIMIT  = 100,
    parameter int unsigned DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] number
);

    localparam int unsigned DPW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW      = DIGITS * 4;
    localparam logic [31:0] LIMIT_V = 32'(LIMIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WORD  = 2'd1;
    localparam logic [1:0] S_DIGIT = 2'd2;
    localparam logic [1:0] S_EOL   = 2'd3;

    logic [1:0]     state;
    logic [31:0]    n;
    logic [1:0]     mod3;
    logic [2:0]     mod5;
    logic [BW-1:0]  bcd;
    logic [2:0]     widx;      // index into "FizzBuzz"
    logic [2:0]     wlast;     // last index of the current word
    logic [DPW-1:0] dpos;      // digit currently emitted (0 = least significant)
    logic           done_q;

    logic           xfer;
    logic           at_limit;
    logic           load;

    // Counter values for the line about to start
    logic [1:0]     nx_m3;
    logic [2:0]     nx_m5;
    logic [BW-1:0]  nx_bcd;
    logic [DPW-1:0] nx_dpos;
    logic [1:0]     nx_state;
    logic [2:0]     nx_widx;
    logic [2:0]     nx_wlast;
    logic           carry;
    logic [3:0]     digit;

    assign out_valid = (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign number    = n;

    assign xfer     = out_valid & out_ready;
    assign at_limit = (n == LIMIT_V);
    // A new line begins on start acceptance or on a newline transfer that is
    // not the final one.
    assign load     = ((state == S_IDLE) && start) ||
                      ((state == S_EOL) && xfer && !at_limit);

    always_comb begin
        nx_bcd = bcd;
        carry  = 1'b1;
        if (state == S_IDLE) begin
            nx_m3  = 2'd1;
            nx_m5  = 3'd1;
            nx_bcd = {{(BW-1){1'b0}}, 1'b1};
        end else begin
            nx_m3 = (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
            nx_m5 = (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry) begin
                    if (nx_bcd[i*4 +: 4] == 4'd9) begin
                        nx_bcd[i*4 +: 4] = 4'd0;
                    end else begin
                        nx_bcd[i*4 +: 4] = nx_bcd[i*4 +: 4] + 4'd1;
                        carry            = 1'b0;
                    end
                end
            end
        end

        // Highest non-zero digit starts the line; a value of zero would still
        // emit digit 0, but N never reaches zero here.
        nx_dpos = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (nx_bcd[i*4 +: 4] != 4'd0) begin
                nx_dpos = DPW'(i);
            end
        end

        // "Fizz" occupies indices 0..3 and "Buzz" 4..7 of "FizzBuzz"
        nx_state = S_DIGIT;
        nx_widx  = 3'd0;
        nx_wlast = 3'd7;
        if (nx_m3 == 2'd0 && nx_m5 == 3'd0) begin
            nx_state = S_WORD;
        end else if (nx_m3 == 2'd0) begin
            nx_state = S_WORD;
            nx_wlast = 3'd3;
        end else if (nx_m5 == 3'd0) begin
            nx_state = S_WORD;
            nx_widx  = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            n      <= 32'd0;
            mod3   <= 2'd0;
            mod5   <= 3'd0;
            bcd    <= '0;
            widx   <= 3'd0;
            wlast  <= 3'd0;
            dpos   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                state <= nx_state;
                n     <= (state == S_IDLE) ? 32'd1 : n + 32'd1;
                mod3  <= nx_m3;
                mod5  <= nx_m5;
                bcd   <= nx_bcd;
                widx  <= nx_widx;
                wlast <= nx_wlast;
                dpos  <= nx_dpos;
            end else begin
                case (state)
                    S_WORD: begin
                        if (xfer) begin
                            if (widx == wlast) state <= S_EOL;
                            else               widx  <= widx + 3'd1;
                        end
                    end
                    S_DIGIT: begin
                        if (xfer) begin
                            if (dpos == '0) state <= S_EOL;
                            else            dpos  <= dpos - DPW'(1);
                        end
                    end
                    S_EOL: begin
                        // Non-final newline transfers are handled by load
                        if (xfer) begin
                            state  <= S_IDLE;
                            n      <= 32'd0;
                            mod3   <= 2'd0;
                            mod5   <= 3'd0;
                            bcd    <= '0;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dpos == DPW'(i)) digit = bcd[i*4 +: 4];
        end
        out_data = 8'h00;
        case (state)
            S_WORD: begin
                case (widx)
                    3'd0:    out_data = 8'h46;  // F
                    3'd1:    out_data = 8'h69;  // i
                    3'd4:    out_data = 8'h42;  // B
                    3'd5:    out_data = 8'h75;  // u
                    default: out_data = 8'h7A;  // z
                endcase
            end
            S_DIGIT: out_data = 8'h30 + {4'h0, digit};
            S_EOL:   out_data = 8'h0A;
            default: out_data = 8'h00;
        endcase
    end

endmodule
`default_nettype wire
